// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type and scan-code prefixes for the PS/2 receiver.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes PS/2 clock and data, debounces the clock, emits a one-cycle fall pulse.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic PS2_clk,
  input  logic PS2_DAT,
  output logic fall,
  output logic dat
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] LAST = FW'(FILTER_LEN - 1);
  logic [1:0] clk_sync, dat_sync;
  logic filt;
  logic [FW-1:0] cnt;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_clk};
      dat_sync <= {dat_sync[0], PS2_DAT};
      fall <= 1'b0;
      if (clk_sync[1] == filt) cnt <= '0;
      else if (cnt == LAST) begin
        filt <= clk_sync[1];
        cnt <= '0;
        fall <= filt;
      end else cnt <= cnt + FW'(1);
    end
  assign dat = dat_sync[1];
endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 keyboard frame receiver delivering make codes with E0 tagging and F0 filtering.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       PS2_clk,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       extended,
  output logic       frame_error
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);
  logic fall, dat;
  ps2_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  logic [WW-1:0] wd;
  logic brk_pend, ext_pend;
  logic par_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic par;
  assign par_ok = ^{par, sr};
`else
  assign par_ok = 1'b1;
`endif
  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .PS2_clk(PS2_clk),
    .PS2_DAT(PS2_DAT),
    .fall(fall),
    .dat(dat)
  );
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      sr <= '0;
      wd <= '0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      data <= '0;
      data_valid <= 1'b0;
      extended <= 1'b0;
      frame_error <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_error <= 1'b0;
      if (state != IDLE && !fall && wd == WD_MAX) begin
        state <= IDLE;
        wd <= '0;
        frame_error <= 1'b1;
      end else begin
        wd <= (state == IDLE || fall) ? '0 : wd + WW'(1);
        if (fall)
          unique case (state)
            IDLE:
              if (!dat) begin
                state <= DATA;
                bit_cnt <= '0;
              end
            DATA: begin
              sr <= {dat, sr[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
              par <= dat;
`endif
              state <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (!dat || !par_ok) frame_error <= 1'b1;
              else if (sr == PS2_BREAK_PREFIX) brk_pend <= 1'b1;
              else if (sr == PS2_EXT_PREFIX) ext_pend <= 1'b1;
              else if (brk_pend) begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
              end else begin
                data <= sr;
                extended <= ext_pend;
                data_valid <= 1'b1;
                ext_pend <= 1'b0;
              end
            end
          endcase
      end
    end
endmodule
